// File: rtl/tdoa_capture.sv
// rtl/tdoa_capture.sv - time-difference-of-arrival capture engine for NUM_CH PCM streams
//
// Timestamps the first sample on each channel whose magnitude reaches a
// programmable threshold, using one shared free-running sample counter.
// Once every channel has fired, it waits a settle window and then holds the
// results for the CPU until ack. If a channel never fires, the engine times
// out after the first trigger and reports a partial result.
//
// Ports:
//   pcm_clk        system clock
//   reset          synchronous, active-high reset
//   sample_en      one-cycle strobe: pcm_data is valid and one sample period has elapsed
//   pcm_data       signed samples; channel i occupies [i*DATA_W +: DATA_W]
//   threshold      unsigned magnitude threshold, latched on arm
//   arm            starts a capture from IDLE
//   ack            CPU has read the results (honoured only in REPORT)
//   trigger_time   per-channel timestamps; channel i occupies [i*TIME_W +: TIME_W]
//   trig_mask      bit i is set once channel i has triggered in this capture
//   result_valid   results are stable and ready for the CPU
//   timed_out      qualifies result_valid: the report is partial
//   busy           a capture is in progress (ARMED, CAPTURE or SETTLE)

module tdoa_capture #(
    parameter int NUM_CH          = 3,
    parameter int DATA_W          = 16,
    parameter int TIME_W          = 32,
    parameter int SETTLE_SAMPLES  = 200,
    parameter int TIMEOUT_SAMPLES = 4096
) (
    input  logic                       pcm_clk,
    input  logic                       reset,
    input  logic                       sample_en,
    input  logic [NUM_CH*DATA_W-1:0]   pcm_data,
    input  logic [DATA_W-2:0]          threshold,
    input  logic                       arm,
    input  logic                       ack,
    output logic [NUM_CH*TIME_W-1:0]   trigger_time,
    output logic [NUM_CH-1:0]          trig_mask,
    output logic                       result_valid,
    output logic                       timed_out,
    output logic                       busy
);

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_SAMPLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SETTLE  = 3'd3,
        S_REPORT  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [TIME_W-1:0]  sample_counter;
    logic [DATA_W-2:0]  threshold_reg;
    logic [23:0]        timeout_cnt;
    logic [15:0]        settle_cnt;

    logic               detect_en;
    logic [NUM_CH-1:0]  hit;
    logic               all_done;
    logic               busy_next;
    logic               valid_next;

    // Detection is only live while waiting for triggers. This keeps the
    // reset threshold of all ones from matching a saturated full-scale
    // sample while the engine sits in IDLE.
    assign detect_en = (state == S_ARMED) || (state == S_CAPTURE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        logic [DATA_W-1:0] smp;
        logic [DATA_W-1:0] neg;
        logic [DATA_W-2:0] mag;

        assign smp = pcm_data[g*DATA_W +: DATA_W];
        assign neg = ~smp + 1'b1;
        // Negating the most negative value leaves the sign bit set.
        // Saturate that case to full scale.
        assign mag = !smp[DATA_W-1] ? smp[DATA_W-2:0]
                   : (neg[DATA_W-1] ? {(DATA_W-1){1'b1}} : neg[DATA_W-2:0]);
        assign hit[g] = detect_en && sample_en && !trig_mask[g] && (mag >= threshold_reg);
    end

    // Completion includes channels that fire on this very sample.
    assign all_done = &(trig_mask | hit);

    // State register
    always_ff @(posedge pcm_clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (arm) next_state = S_ARMED;
            end
            S_ARMED: begin
                if (|hit) next_state = all_done ? S_SETTLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (sample_en) begin
                    // Completion takes priority over a timeout on the same sample.
                    if (all_done) begin
                        next_state = S_SETTLE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        next_state = S_REPORT;
                    end
                end
            end
            S_SETTLE: begin
                if (sample_en && (settle_cnt == SETTLE_LAST)) next_state = S_REPORT;
            end
            S_REPORT: begin
                if (ack) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the next state. The result is registered below,
    // so busy and result_valid change on the same edge as the state.
    always_comb begin
        busy_next  = 1'b0;
        valid_next = 1'b0;
        case (next_state)
            S_ARMED, S_CAPTURE, S_SETTLE: busy_next  = 1'b1;
            S_REPORT:                     valid_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pcm_clk) begin
        if (reset) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            busy         <= busy_next;
            result_valid <= valid_next;
        end
    end

    // Sample counter, threshold and counters for the capture windows
    always_ff @(posedge pcm_clk) begin
        if (reset) begin
            sample_counter <= '0;
            threshold_reg  <= '1;
            timeout_cnt    <= '0;
            settle_cnt     <= '0;
        end else begin
            if (sample_en) sample_counter <= sample_counter + 1'b1;

            if ((state == S_IDLE) && arm) threshold_reg <= threshold;

            if (state == S_ARMED) begin
                timeout_cnt <= '0;
            end else if ((state == S_CAPTURE) && sample_en) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            if ((state != S_SETTLE) && (next_state == S_SETTLE)) begin
                settle_cnt <= '0;
            end else if ((state == S_SETTLE) && sample_en) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // Capture results: these hold through REPORT and IDLE until the next arm.
    always_ff @(posedge pcm_clk) begin
        if (reset) begin
            trigger_time <= '0;
            trig_mask    <= '0;
            timed_out    <= 1'b0;
        end else if ((state == S_IDLE) && arm) begin
            trigger_time <= '0;
            trig_mask    <= '0;
            timed_out    <= 1'b0;
        end else begin
            trig_mask <= trig_mask | hit;
            for (int i = 0; i < NUM_CH; i++) begin
                // The timestamp is the counter value before this sample's increment.
                if (hit[i]) trigger_time[i*TIME_W +: TIME_W] <= sample_counter;
            end
            if ((state == S_CAPTURE) && (next_state == S_REPORT)) timed_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tdoa_capture.sv
// tb/tb_tdoa_capture.sv - directed self-checking bench for tdoa_capture

module tb_tdoa_capture;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int TW  = 8;

    logic              pcm_clk = 1'b0;
    logic              reset = 1'b1;
    logic              sample_en = 1'b0;
    logic [NCH*DW-1:0] pcm_data = '0;
    logic [DW-2:0]     threshold = '0;
    logic              arm = 1'b0;
    logic              ack = 1'b0;
    logic [NCH*TW-1:0] trigger_time;
    logic [NCH-1:0]    trig_mask;
    logic              result_valid;
    logic              timed_out;
    logic              busy;

    int pass_cnt = 0;
    int total    = 0;
    int cnt      = 0;

    tdoa_capture #(
        .NUM_CH(NCH), .DATA_W(DW), .TIME_W(TW),
        .SETTLE_SAMPLES(200), .TIMEOUT_SAMPLES(4096)
    ) dut (
        .pcm_clk(pcm_clk), .reset(reset), .sample_en(sample_en), .pcm_data(pcm_data),
        .threshold(threshold), .arm(arm), .ack(ack), .trigger_time(trigger_time),
        .trig_mask(trig_mask), .result_valid(result_valid), .timed_out(timed_out), .busy(busy)
    );

    always #5 pcm_clk = ~pcm_clk;

    task automatic step();
        @(posedge pcm_clk);
        #1;
    endtask

    task automatic sample(input logic signed [DW-1:0] s0, input logic signed [DW-1:0] s1,
                          input logic signed [DW-1:0] s2);
        pcm_data  = {s2, s1, s0};
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        pcm_data  = '0;
        cnt++;
    endtask

    task automatic run_to(input int target);
        while ((cnt % 256) != target) sample(16'sd0, 16'sd0, 16'sd0);
    endtask

    task automatic do_arm(input logic [DW-2:0] thr);
        threshold = thr;
        arm = 1'b1;
        step();
        arm = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL arm_busy: got %b want 1", busy);
        else pass_cnt++;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++;
        if ({result_valid, busy} !== 2'b00)
            $display("FAIL ack_valid_busy: got %b want 00", {result_valid, busy});
        else pass_cnt++;
    endtask

    task automatic check_out(input string name, input logic [NCH*TW-1:0] t, input logic [NCH-1:0] m,
                             input logic v, input logic to, input logic b);
        total++;
        if ({trigger_time, trig_mask, result_valid, timed_out, busy} !== {t, m, v, to, b})
            $display("FAIL %s: got time=%h mask=%b valid=%b to=%b busy=%b want time=%h mask=%b valid=%b to=%b busy=%b",
                     name, trigger_time, trig_mask, result_valid, timed_out, busy, t, m, v, to, b);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        cnt = 0;
        check_out("reset", '0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_normal();
        do_arm(15'd1000);
        run_to(10);
        sample(16'sd1200, 16'sd0, 16'sd0);
        check_out("normal_ch0", {8'd0, 8'd0, 8'd10}, 3'b001, 1'b0, 1'b0, 1'b1);
        run_to(14);
        sample(16'sd0, -16'sd1500, 16'sd0);
        run_to(17);
        sample(16'sd0, 16'sd0, 16'sd1000);
        check_out("normal_all", {8'd17, 8'd14, 8'd10}, 3'b111, 1'b0, 1'b0, 1'b1);
        run_to(217);
        check_out("normal_pre", {8'd17, 8'd14, 8'd10}, 3'b111, 1'b0, 1'b0, 1'b1);
        sample(16'sd0, 16'sd0, 16'sd0);
        check_out("normal_report", {8'd17, 8'd14, 8'd10}, 3'b111, 1'b1, 1'b0, 1'b0);
        do_ack();
    endtask

    task automatic test_timeout();
        int t0;
        do_arm(15'd1000);
        run_to(10);
        t0 = cnt;
        sample(16'sd1200, 16'sd0, 16'sd0);
        run_to(14);
        sample(16'sd0, -16'sd1500, 16'sd0);
        while (cnt != t0 + 4096) sample(16'sd0, 16'sd0, 16'sd0);
        check_out("timeout_pre", {8'd0, 8'd14, 8'd10}, 3'b011, 1'b0, 1'b0, 1'b1);
        sample(16'sd0, 16'sd0, 16'sd0);
        check_out("timeout_report", {8'd0, 8'd14, 8'd10}, 3'b011, 1'b1, 1'b1, 1'b0);
        do_ack();
    endtask

    task automatic test_simultaneous();
        do_arm(15'd32767);
        run_to(5);
        sample(-16'sd32768, -16'sd32768, -16'sd32768);
        check_out("simul_all", {8'd5, 8'd5, 8'd5}, 3'b111, 1'b0, 1'b0, 1'b1);
        // A direct ARMED->SETTLE transition reports exactly 200 samples later.
        for (int i = 0; i < 199; i++) sample(16'sd0, 16'sd0, 16'sd0);
        check_out("simul_pre", {8'd5, 8'd5, 8'd5}, 3'b111, 1'b0, 1'b0, 1'b1);
        sample(16'sd0, 16'sd0, 16'sd0);
        check_out("simul_report", {8'd5, 8'd5, 8'd5}, 3'b111, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_hold_ack();
        for (int i = 0; i < 1000; i++) sample(-16'sd32768, 16'sd30000, -16'sd30000);
        check_out("hold_report", {8'd5, 8'd5, 8'd5}, 3'b111, 1'b1, 1'b0, 1'b0);
        do_ack();
        check_out("hold_idle", {8'd5, 8'd5, 8'd5}, 3'b111, 1'b0, 1'b0, 1'b0);
        do_arm(15'd1000);
        check_out("rearm_clear", '0, 3'b000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        run_to(254);
        sample(16'sd1200, 16'sd0, 16'sd0);
        run_to(1);
        sample(16'sd0, -16'sd1500, 16'sd0);
        sample(16'sd0, 16'sd0, 16'sd2000);
        check_out("wrap_times", {8'd2, 8'd1, 8'd254}, 3'b111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) sample(16'sd0, 16'sd0, 16'sd0);
        check_out("wrap_report", {8'd2, 8'd1, 8'd254}, 3'b111, 1'b1, 1'b0, 1'b0);
        do_ack();
    endtask

    task automatic test_reset_capture();
        logic [7:0] exp_t;
        do_arm(15'd1000);
        sample(16'sd1200, 16'sd0, 16'sd0);
        total++;
        if (trig_mask !== 3'b001) $display("FAIL rc_mask: got %b want 001", trig_mask);
        else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt = 0;
        check_out("rc_reset", '0, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sample(-16'sd32768, -16'sd32768, -16'sd32768);
        check_out("rc_no_trig", '0, 3'b000, 1'b0, 1'b0, 1'b0);
        do_arm(15'd500);
        exp_t = 8'(cnt);
        sample(16'sd0, 16'sd600, 16'sd0);
        check_out("rc_new_thr", {8'd0, exp_t, 8'd0}, 3'b010, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_simultaneous();
        test_hold_ack();
        test_wrap();
        test_reset_capture();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
